// File: rtl/uart_song_loader.sv
// uart_song_loader: receives a song image over an 8N1 UART as 16-bit words
// (high byte first), writes them to consecutive SRAM addresses from 0, and
// releases the music CPU once the end instruction (bits [15:12] == 0) is stored.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing 16-bit checksum check
// and the CKSUM_ERR output.
module uart_song_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 18
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              UART_RX,
   output logic              SRAM_WE,
   output logic              SRAM_CE,
   output logic              SRAM_OE,
   output logic              SRAM_LB,
   output logic              SRAM_UB,
   output logic [ADDR_W-1:0] SRAM_A,
   output logic [15:0]       SRAM_DQ_OUT,
   output logic              SRAM_DQ_OE,
   output logic              CPU_RUN,
   output logic [ADDR_W-1:0] WORD_COUNT,
`ifdef LOADER_CHECKSUM_EN
   output logic              CKSUM_ERR,
`endif
   output logic              FRAME_ERR
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {W_IDLE, W_SETUP, W_PULSE, W_HOLD, W_DONE, W_CK_WAIT, W_CK_FAIL} wr_state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam wr_state_t END_STATE = W_CK_WAIT;
`else
   localparam wr_state_t END_STATE = W_DONE;
`endif

   // The chip is always selected with both byte lanes enabled.
   assign SRAM_CE = 1'b0;
   assign SRAM_LB = 1'b0;
   assign SRAM_UB = 1'b0;

   logic rx_meta_q, rx_sync_q, rx_prev_q;

   rx_state_t        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             byte_valid, stop_err;

   logic             phase_q, phase_d;
   logic [7:0]       hi_byte_q, hi_byte_d;
   logic [15:0]      word_q, word_d;
   logic             word_ready_q, word_ready_d;
   logic             frame_err_q, frame_err_d;
   logic             accepting;

   wr_state_t        wr_state_q, wr_state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [15:0]      dq_out_q, dq_out_d;
   logic             we_q, oe_q, dq_oe_q, cpu_run_q;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0]      sum_q, sum_d;
   logic             cksum_err_q;
`endif

   // Two-flop synchronizer plus a delayed copy for start-bit edge detection.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= UART_RX;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // Receiver: find the start bit, sample mid-bit, shift in LSB first, check stop.
   always_comb begin
      rx_state_d = rx_state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      byte_valid = 1'b0;
      stop_err   = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            clk_cnt_d = '0;
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = R_START;
               bit_cnt_d  = '0;
            end
         end
         R_START: begin
            if (clk_cnt_q == HALF_LAST) begin
               clk_cnt_d  = '0;
               rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         R_DATA: begin
            if (clk_cnt_q == FULL_LAST) begin
               clk_cnt_d = '0;
               shift_d   = {rx_sync_q, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  rx_state_d = R_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         R_STOP: begin
            if (clk_cnt_q == FULL_LAST) begin
               clk_cnt_d  = '0;
               rx_state_d = R_IDLE;
               if (rx_sync_q) begin
                  byte_valid = 1'b1;
               end else begin
                  stop_err = 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = R_IDLE;
      endcase
   end

   // Word assembly; once the loader has finished, received bytes and framing errors are ignored.
   always_comb begin
      accepting    = (wr_state_q != W_DONE) && (wr_state_q != W_CK_FAIL);
      phase_d      = phase_q;
      hi_byte_d    = hi_byte_q;
      word_d       = word_q;
      word_ready_d = 1'b0;
      frame_err_d  = frame_err_q;
      if (accepting) begin
         if (stop_err) begin
            frame_err_d = 1'b1;
         end
         if (byte_valid) begin
            if (!phase_q) begin
               hi_byte_d = shift_q;
               phase_d   = 1'b1;
            end else begin
               word_d       = {hi_byte_q, shift_q};
               word_ready_d = 1'b1;
               phase_d      = 1'b0;
            end
         end
      end
   end

   // Write sequencer: setup, WE pulse, hold, then advance address or finish.
   always_comb begin
      wr_state_d = wr_state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      dq_out_d   = dq_out_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d      = sum_q;
`endif
      case (wr_state_q)
         W_IDLE: begin
            if (word_ready_q) begin
               dq_out_d   = word_q;
               wr_state_d = W_SETUP;
            end
         end
         W_SETUP: wr_state_d = W_PULSE;
         W_PULSE: wr_state_d = W_HOLD;
         W_HOLD: begin
            // The count saturates when every address has been written, since that total does not fit.
            count_d = (count_q == ADDR_MAX) ? count_q : count_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = sum_q + dq_out_q;
`endif
            if (addr_q != ADDR_MAX) begin
               addr_d = addr_q + 1'b1;
            end
            if ((dq_out_q[15:12] == 4'b0000) || (addr_q == ADDR_MAX)) begin
               wr_state_d = END_STATE;
            end else begin
               wr_state_d = W_IDLE;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         W_CK_WAIT: begin
            if (word_ready_q) begin
               wr_state_d = (word_q == sum_q) ? W_DONE : W_CK_FAIL;
            end
         end
`endif
         default: wr_state_d = wr_state_q;
      endcase
   end

   // State and registered outputs, all cleared asynchronously so a reset mid-write releases the bus at once.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_state_q   <= R_IDLE;
         clk_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         phase_q      <= 1'b0;
         hi_byte_q    <= '0;
         word_q       <= '0;
         word_ready_q <= 1'b0;
         frame_err_q  <= 1'b0;
         wr_state_q   <= W_IDLE;
         addr_q       <= '0;
         count_q      <= '0;
         dq_out_q     <= '0;
         we_q         <= 1'b1;
         oe_q         <= 1'b1;
         dq_oe_q      <= 1'b0;
         cpu_run_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q        <= '0;
         cksum_err_q  <= 1'b0;
`endif
      end else begin
         rx_state_q   <= rx_state_d;
         clk_cnt_q    <= clk_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         phase_q      <= phase_d;
         hi_byte_q    <= hi_byte_d;
         word_q       <= word_d;
         word_ready_q <= word_ready_d;
         frame_err_q  <= frame_err_d;
         wr_state_q   <= wr_state_d;
         addr_q       <= addr_d;
         count_q      <= count_d;
         dq_out_q     <= dq_out_d;
         we_q         <= (wr_state_d != W_PULSE);
         oe_q         <= (wr_state_d != W_DONE);
         dq_oe_q      <= (wr_state_d == W_SETUP) || (wr_state_d == W_PULSE) || (wr_state_d == W_HOLD);
         cpu_run_q    <= (wr_state_d == W_DONE);
`ifdef LOADER_CHECKSUM_EN
         sum_q        <= sum_d;
         cksum_err_q  <= (wr_state_d == W_CK_FAIL);
`endif
      end
   end

   assign SRAM_WE     = we_q;
   assign SRAM_OE     = oe_q;
   assign SRAM_A      = addr_q;
   assign SRAM_DQ_OUT = dq_out_q;
   assign SRAM_DQ_OE  = dq_oe_q;
   assign CPU_RUN     = cpu_run_q;
   assign WORD_COUNT  = count_q;
   assign FRAME_ERR   = frame_err_q;
`ifdef LOADER_CHECKSUM_EN
   assign CKSUM_ERR   = cksum_err_q;
`endif

endmodule

// File: tb/tb_uart_song_loader.sv
// Testbench for uart_song_loader: directed songs plus randomized songs checked
// against a byte-stream reference model of the loader.
module tb_uart_song_loader;

   localparam int CPB   = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          UART_RX;
   logic          SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB;
   logic [AW-1:0] SRAM_A;
   logic [15:0]   SRAM_DQ_OUT;
   logic          SRAM_DQ_OE, CPU_RUN, FRAME_ERR;
   logic [AW-1:0] WORD_COUNT;
`ifdef LOADER_CHECKSUM_EN
   logic          CKSUM_ERR;
`endif

   uart_song_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
      .CLK(CLK), .RST_N(RST_N), .UART_RX(UART_RX),
      .SRAM_WE(SRAM_WE), .SRAM_CE(SRAM_CE), .SRAM_OE(SRAM_OE),
      .SRAM_LB(SRAM_LB), .SRAM_UB(SRAM_UB), .SRAM_A(SRAM_A),
      .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE), .CPU_RUN(CPU_RUN),
      .WORD_COUNT(WORD_COUNT),
`ifdef LOADER_CHECKSUM_EN
      .CKSUM_ERR(CKSUM_ERR),
`endif
      .FRAME_ERR(FRAME_ERR)
   );

   always #5 CLK = ~CLK;

   int assertCount = 0;
   int failCount   = 0;

   // Byte stream sent to the DUT: value and whether its stop bit is good.
   logic [7:0] qB[$];
   bit         qOk[$];

   // SRAM image and write activity seen on the bus.
   logic [15:0] mem[DEPTH];
   int          wePulses;
   int          cyc = 0;
   int          lastWeCycle;
   int          cpuRiseCycle;
   bit          cpuSeen;

   // Model results.
   logic [15:0] expMem[DEPTH];
   int          expN;
   bit          expFerr, expCpu, expCkErr;

   // Bus monitor sampled on the falling edge, where the DUT outputs are stable.
   always @(negedge CLK) begin
      cyc++;
      if (RST_N === 1'b1) begin
         if (SRAM_WE === 1'b0) begin
            wePulses++;
            lastWeCycle = cyc;
            if (SRAM_DQ_OE === 1'b1) mem[SRAM_A] = SRAM_DQ_OUT;
         end
         if (CPU_RUN === 1'b1 && !cpuSeen) begin
            cpuSeen = 1'b1;
            cpuRiseCycle = cyc;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearMonitor();
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDEAD;
      wePulses = 0;
      lastWeCycle = 0;
      cpuRiseCycle = -1;
      cpuSeen = 1'b0;
   endtask

   task automatic doReset();
      RST_N = 1'b0;
      UART_RX = 1'b1;
      repeat (3) @(negedge CLK);
      clearMonitor();
      qB.delete();
      qOk.delete();
      RST_N = 1'b1;
      repeat (2 * CPB) @(negedge CLK);
   endtask

   task automatic pushByte(input logic [7:0] b, input bit ok);
      qB.push_back(b);
      qOk.push_back(ok);
   endtask

   task automatic sendByte(input logic [7:0] b, input bit stopOk);
      UART_RX = 1'b0;
      repeat (CPB) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         UART_RX = b[i];
         repeat (CPB) @(negedge CLK);
      end
      UART_RX = stopOk;
      repeat (CPB) @(negedge CLK);
      UART_RX = 1'b1;
      repeat (2 * CPB) @(negedge CLK);
   endtask

   task automatic applyStimulus(input int from);
      for (int i = from; i < qB.size(); i++) sendByte(qB[i], qOk[i]);
   endtask

   // Reference model: walk the byte stream as the loader's rules describe it.
   task automatic runModel();
      int stage;   // 0 loading, 1 awaiting checksum, 2 done, 3 checksum failed
      bit phaseLo;
      logic [7:0] hi;
      logic [15:0] w, sum;
      stage = 0; phaseLo = 0; hi = 0; sum = 0;
      expN = 0; expFerr = 0;
      for (int i = 0; i < qB.size(); i++) begin
         if (stage >= 2) continue;
         if (!qOk[i]) begin
            expFerr = 1;
            continue;
         end
         if (!phaseLo) begin
            hi = qB[i];
            phaseLo = 1;
            continue;
         end
         phaseLo = 0;
         w = {hi, qB[i]};
         if (stage == 1) begin
            stage = (w == sum) ? 2 : 3;
            continue;
         end
         expMem[expN] = w;
         expN++;
         sum = sum + w;
         if (w[15:12] == 4'h0 || expN == DEPTH) stage = CK ? 1 : 2;
      end
      expCpu = (stage == 2);
      expCkErr = (stage == 3);
   endtask

   task automatic checkSong(input string tag);
      int expCount;
      runModel();
      expCount = (expN == DEPTH) ? DEPTH - 1 : expN;
      checkOutput({tag, "_count"}, WORD_COUNT, expCount);
      checkOutput({tag, "_ferr"}, FRAME_ERR, expFerr);
      checkOutput({tag, "_cpu"}, CPU_RUN, expCpu);
      checkOutput({tag, "_oe"}, SRAM_OE, !expCpu);
      checkOutput({tag, "_we"}, SRAM_WE, 1);
      checkOutput({tag, "_dqoe"}, SRAM_DQ_OE, 0);
      checkOutput({tag, "_pulses"}, wePulses, expN);
      for (int i = 0; i < expN; i++) checkOutput($sformatf("%s_mem%0d", tag, i), mem[i], expMem[i]);
      if (expN < DEPTH) checkOutput({tag, "_unwritten"}, mem[expN], 16'hDEAD);
`ifdef LOADER_CHECKSUM_EN
      checkOutput({tag, "_ckerr"}, CKSUM_ERR, expCkErr);
`endif
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_we"}, SRAM_WE, 1);
      checkOutput({tag, "_ce"}, SRAM_CE, 0);
      checkOutput({tag, "_oe"}, SRAM_OE, 1);
      checkOutput({tag, "_lbub"}, {SRAM_LB, SRAM_UB}, 0);
      checkOutput({tag, "_a"}, SRAM_A, 0);
      checkOutput({tag, "_dq"}, SRAM_DQ_OUT, 0);
      checkOutput({tag, "_dqoe"}, SRAM_DQ_OE, 0);
      checkOutput({tag, "_cpu"}, CPU_RUN, 0);
      checkOutput({tag, "_count"}, WORD_COUNT, 0);
      checkOutput({tag, "_ferr"}, FRAME_ERR, 0);
   endtask

   task automatic pushTest1();
      pushByte(8'h10, 1); pushByte(8'h60, 1);
      pushByte(8'h81, 1); pushByte(8'h23, 1);
      pushByte(8'h00, 1); pushByte(8'h00, 1);
   endtask

   initial begin
      int base;
      int len;
      logic [15:0] w;
      $display("[TB] starting uart_song_loader bench");
      RST_N = 1'b0;
      UART_RX = 1'b1;
      clearMonitor();
      repeat (3) @(negedge CLK);
      checkReset("reset");
      doReset();

      // Short low glitch on the line must not start a byte.
      UART_RX = 1'b0;
      repeat (CPB / 4) @(negedge CLK);
      UART_RX = 1'b1;
      repeat (4 * CPB) @(negedge CLK);
      checkOutput("glitch_count", WORD_COUNT, 0);
      checkOutput("glitch_ferr", FRAME_ERR, 0);
      checkOutput("glitch_pulses", wePulses, 0);
      checkOutput("glitch_cpu", CPU_RUN, 0);

      // Basic three-word song.
      pushTest1();
      applyStimulus(0);
      checkSong("t1");
`ifndef LOADER_CHECKSUM_EN
      checkOutput("t1_cpu_latency", cpuRiseCycle - lastWeCycle, 2);
`endif

      // Bytes after the song, including a bad stop bit.
      base = qB.size();
      pushByte(8'h12, 1); pushByte(8'h34, 1); pushByte(8'h55, 0);
      applyStimulus(base);
      checkSong("t5");

      // Framing error on the first byte is dropped without disturbing byte phase.
      doReset();
      pushByte(8'h80, 0);
      pushByte(8'h81, 1); pushByte(8'h23, 1);
      pushByte(8'h00, 1); pushByte(8'h00, 1);
      applyStimulus(0);
      checkSong("t2");

      // Reset while the second word is being strobed into SRAM.
      doReset();
      pushTest1();
      for (int i = 0; i < 3; i++) sendByte(qB[i], 1);
      fork
         sendByte(qB[3], 1);
         begin
            int k;
            k = 0;
            while (SRAM_WE !== 1'b0 && k < 40 * CPB) begin
               @(negedge CLK);
               k++;
            end
            checkOutput("t4_pulse_seen", (k < 40 * CPB), 1);
            checkOutput("t4_pulse_addr", SRAM_A, 1);
            RST_N = 1'b0;
            #1;
            checkOutput("t4_we", SRAM_WE, 1);
            checkOutput("t4_dqoe", SRAM_DQ_OE, 0);
            checkOutput("t4_a", SRAM_A, 0);
            checkOutput("t4_count", WORD_COUNT, 0);
         end
      join
      doReset();
      pushTest1();
      applyStimulus(0);
      checkSong("t4_reload");

      // Random songs; the first one runs past the last address to hit the wrap stop.
      for (int it = 0; it < 8; it++) begin
         doReset();
         len = (it == 0) ? DEPTH + 2 : int'($urandom_range(1, 6));
         for (int n = 0; n < len; n++) begin
            if (n == len - 1 && it != 0) w = {4'h0, 12'($urandom)};
            else w = {4'($urandom_range(1, 15)), 12'($urandom)};
            if ($urandom_range(0, 7) == 0) pushByte(8'($urandom), 0);
            pushByte(w[15:8], 1);
            pushByte(w[7:0], 1);
         end
         pushByte(8'($urandom), 1);
         pushByte(8'($urandom), 1);
         applyStimulus(0);
         checkSong($sformatf("rand%0d", it));
      end

`ifdef LOADER_CHECKSUM_EN
      // Checksum match and mismatch.
      doReset();
      pushByte(8'h81, 1); pushByte(8'h23, 1); pushByte(8'h00, 1); pushByte(8'h00, 1);
      pushByte(8'h81, 1); pushByte(8'h23, 1);
      applyStimulus(0);
      checkSong("t6_match");
      checkOutput("t6_match_cpu", CPU_RUN, 1);
      doReset();
      pushByte(8'h81, 1); pushByte(8'h23, 1); pushByte(8'h00, 1); pushByte(8'h00, 1);
      pushByte(8'h81, 1); pushByte(8'h24, 1);
      applyStimulus(0);
      checkSong("t6_mismatch");
      checkOutput("t6_mismatch_ckerr", CKSUM_ERR, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
